// File: rtl/bus_config_sequencer.sv
// Board-level configuration sequencer: debounces two keys and walks the per-master
// setup flow (slave select, r/w, external writes, address window), then start / done / read-back.
module bus_config_sequencer #(
  parameter int MASTER_COUNT    = 2,
  parameter int SLAVE_COUNT     = 3,
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_EXT_WRITE   = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SW_WIDTH        = 18,
  localparam int SEL_W          = $clog2(SLAVE_COUNT + 1),
  localparam int EW_W           = $clog2(MAX_EXT_WRITE)
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [SW_WIDTH-1:0]              sw,
  input  logic                             jump_stateN,
  input  logic                             jump_next_addrN,
  input  logic                             comm_done,
  output logic [MASTER_COUNT*SEL_W-1:0]    mst_slave_sel,
  output logic [MASTER_COUNT-1:0]          mst_rw,
  output logic [MASTER_COUNT-1:0]          mst_ext_en,
  output logic [MASTER_COUNT-1:0]          ext_wr_en,
  output logic [EW_W-1:0]                  ext_wr_addr,
  output logic [DATA_WIDTH-1:0]            ext_wr_data,
  output logic [MASTER_COUNT*ADDR_WIDTH-1:0] mst_start_addr,
  output logic [MASTER_COUNT*ADDR_WIDTH-1:0] mst_addr_count,
  output logic                             comm_ready,
  output logic                             comm_start,
  output logic                             comm_finished,
  output logic                             rd_req,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [3:0]                       cfg_state
);

  localparam int M_W  = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [3:0] {
    S_SLAVE_SEL  = 4'd0,
    S_RW_SEL     = 4'd1,
    S_EXT_SEL    = 4'd2,
    S_EXT_WRITE  = 4'd3,
    S_START_ADDR = 4'd4,
    S_ADDR_COUNT = 4'd5,
    S_READY      = 4'd6,
    S_COMM       = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  state_t state, state_next;

  logic [SW_WIDTH-1:0]       sw_p0, sw_p1;
  logic [1:0]                key_p0, key_p1;
  logic [1:0]                armed, press;
  logic [1:0][DB_W-1:0]      db_cnt;
  logic [M_W-1:0]            m;
  logic [EW_W-1:0]           wr_idx;
  logic                      st_press, nx_press, last_m;
  logic [M_W:0]              first_pick, next_pick;
  logic                      unused_bits;

  // Clamp the word count so the window never runs past the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] start,
                                                        input logic [ADDR_WIDTH-1:0] count);
    logic [ADDR_WIDTH:0] sum;
    logic [ADDR_WIDTH:0] lim;
    sum = {1'b0, start} + {1'b0, count};
    lim = {1'b1, {ADDR_WIDTH{1'b0}}};
    if (sum > lim) return ADDR_WIDTH'(lim - {1'b0, start});
    return count;
  endfunction

  // Lowest enabled master at or above 'from'; MSB flags whether one exists.
  function automatic logic [M_W:0] pick_master(input logic [MASTER_COUNT-1:0] en, input int from);
    logic [M_W:0] r;
    r = '0;
    for (int i = MASTER_COUNT - 1; i >= 0; i--)
      if (en[i] && i >= from) r = {1'b1, M_W'(i)};
    return r;
  endfunction

  // Stage p0/p1: synchronisers, then debounce. An armed key counts lows, a fired key counts highs to re-arm.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      key_p0 <= '0;
      key_p1 <= '0;
      armed  <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      key_p0 <= {jump_next_addrN, jump_stateN};
      key_p1 <= key_p0;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (armed[k] ^ key_p1[k]) begin
          if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt[k] <= '0;
            armed[k]  <= ~armed[k];
            press[k]  <= armed[k];
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign st_press    = press[0];
  assign nx_press    = press[1] & ~press[0];
  assign last_m      = (m == M_W'(MASTER_COUNT - 1));
  assign first_pick  = pick_master(sw_p1[MASTER_COUNT-1:0], 0);
  assign next_pick   = pick_master(mst_ext_en, int'(m) + 1);
  assign unused_bits = ^{sw_p1, first_pick[M_W]};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_SLAVE_SEL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SLAVE_SEL:  if (st_press) state_next = S_RW_SEL;
      S_RW_SEL:     if (st_press) state_next = S_EXT_SEL;
      S_EXT_SEL:    if (st_press) state_next = first_pick[M_W] ? S_EXT_WRITE : S_START_ADDR;
      S_EXT_WRITE:  if (st_press && !next_pick[M_W]) state_next = S_START_ADDR;
      S_START_ADDR: if (st_press && last_m) state_next = S_ADDR_COUNT;
      S_ADDR_COUNT: if (st_press && last_m) state_next = S_READY;
      S_READY:      if (st_press) state_next = S_COMM;
      S_COMM:       if (comm_done) state_next = S_DONE;
      S_DONE:       state_next = S_DONE;
      default:      state_next = S_SLAVE_SEL;
    endcase
  end

  assign comm_ready    = (state == S_READY);
  assign comm_finished = (state == S_DONE);
  assign cfg_state     = state;

  // Stage p2: configuration registers and single-cycle strobes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mst_slave_sel  <= '0;
      mst_rw         <= '0;
      mst_ext_en     <= '0;
      ext_wr_en      <= '0;
      ext_wr_addr    <= '0;
      ext_wr_data    <= '0;
      mst_start_addr <= '0;
      mst_addr_count <= '0;
      comm_start     <= 1'b0;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      m              <= '0;
      wr_idx         <= '0;
    end else begin
      ext_wr_en  <= '0;
      comm_start <= 1'b0;
      rd_req     <= 1'b0;
      case (state)
        S_SLAVE_SEL: if (st_press) mst_slave_sel <= sw_p1[MASTER_COUNT*SEL_W-1:0];
        S_RW_SEL:    if (st_press) mst_rw <= sw_p1[MASTER_COUNT-1:0];
        S_EXT_SEL: if (st_press) begin
          mst_ext_en <= sw_p1[MASTER_COUNT-1:0];
          m          <= first_pick[M_W-1:0];
          wr_idx     <= '0;
        end
        S_EXT_WRITE: begin
          if (st_press) begin
            ext_wr_en   <= MASTER_COUNT'(1) << m;
            ext_wr_addr <= wr_idx;
            ext_wr_data <= sw_p1[DATA_WIDTH-1:0];
            wr_idx      <= '0;
            m           <= next_pick[M_W] ? next_pick[M_W-1:0] : '0;
          end else if (nx_press && wr_idx != EW_W'(MAX_EXT_WRITE - 1)) begin
            ext_wr_en   <= MASTER_COUNT'(1) << m;
            ext_wr_addr <= wr_idx;
            ext_wr_data <= sw_p1[DATA_WIDTH-1:0];
            wr_idx      <= wr_idx + 1'b1;
          end
        end
        S_START_ADDR: if (st_press) begin
          mst_start_addr[m*ADDR_WIDTH +: ADDR_WIDTH] <= sw_p1[ADDR_WIDTH-1:0];
          m <= last_m ? '0 : m + 1'b1;
        end
        S_ADDR_COUNT: if (st_press) begin
          mst_addr_count[m*ADDR_WIDTH +: ADDR_WIDTH] <=
            clamp_count(mst_start_addr[m*ADDR_WIDTH +: ADDR_WIDTH], sw_p1[ADDR_WIDTH-1:0]);
          m <= last_m ? '0 : m + 1'b1;
        end
        S_READY: if (st_press) comm_start <= 1'b1;
        S_DONE: if (st_press) begin
          rd_addr <= sw_p1[ADDR_WIDTH-1:0];
          rd_req  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_config_sequencer.sv
// Directed bench for bus_config_sequencer: walks the full setup flow three times
// with hand-computed expectations for config values, write strobes and handshakes.
module tb_bus_config_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [17:0] sw;
  logic        jump_stateN, jump_next_addrN, comm_done;
  logic [3:0]  mst_slave_sel;
  logic [1:0]  mst_rw, mst_ext_en, ext_wr_en;
  logic [3:0]  ext_wr_addr;
  logic [15:0] ext_wr_data;
  logic [23:0] mst_start_addr, mst_addr_count;
  logic        comm_ready, comm_start, comm_finished, rd_req;
  logic [11:0] rd_addr;
  logic [3:0]  cfg_state;

  int checks = 0;
  int errors = 0;
  int log_n  = 0;
  int cs_cnt = 0;
  int rd_cnt = 0;
  logic [21:0] log_ent [0:63];
  int base, cs0, rd0;

  bus_config_sequencer dut (
    .clk(clk), .rstN(rstN), .sw(sw),
    .jump_stateN(jump_stateN), .jump_next_addrN(jump_next_addrN), .comm_done(comm_done),
    .mst_slave_sel(mst_slave_sel), .mst_rw(mst_rw), .mst_ext_en(mst_ext_en),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .mst_start_addr(mst_start_addr), .mst_addr_count(mst_addr_count),
    .comm_ready(comm_ready), .comm_start(comm_start), .comm_finished(comm_finished),
    .rd_req(rd_req), .rd_addr(rd_addr), .cfg_state(cfg_state)
  );

  always #5 clk = ~clk;

  // Strobe recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (|ext_wr_en) begin
      if (log_n < 64) log_ent[log_n] = {ext_wr_en, ext_wr_addr, ext_wr_data};
      log_n = log_n + 1;
    end
    if (comm_start) cs_cnt = cs_cnt + 1;
    if (rd_req) rd_cnt = rd_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic st, input logic nx, input int low_cycles);
    jump_stateN     = ~st;
    jump_next_addrN = ~nx;
    cycles(low_cycles);
    jump_stateN     = 1'b1;
    jump_next_addrN = 1'b1;
    cycles(14);
  endtask

  task automatic press_state(input logic [17:0] v);
    sw = v;
    cycles(2);
    press(1'b1, 1'b0, 12);
  endtask

  task automatic press_next(input logic [17:0] v);
    sw = v;
    cycles(2);
    press(1'b0, 1'b1, 12);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    cycles(3);
    rstN = 1'b1;
    cycles(14);
  endtask

  function automatic logic [21:0] ent(input int i);
    return (i < 64) ? log_ent[i] : 22'h3FFFFF;
  endfunction

  initial begin
    rstN = 1'b0; sw = '0; jump_stateN = 1'b1; jump_next_addrN = 1'b1; comm_done = 1'b0;
    cycles(3);
    chk("rst_state", cfg_state, 4'd0);
    chk("rst_sel", mst_slave_sel, 4'h0);
    chk("rst_cfg", {mst_rw, mst_ext_en, mst_start_addr, mst_addr_count}, '0);
    chk("rst_strobes", {ext_wr_en, comm_start, rd_req, comm_ready, comm_finished}, '0);
    rstN = 1'b1;
    cycles(14);

    // Pass 1: two masters, both with external writes.
    press_state(18'h9);
    chk("slave_sel", mst_slave_sel, 4'b1001);
    chk("state_rw", cfg_state, 4'd1);
    chk("no_strobe", log_n + cs_cnt + rd_cnt, 0);
    press_state(18'h1);
    chk("rw", mst_rw, 2'b01);
    press_state(18'h3);
    chk("ext_en", mst_ext_en, 2'b11);
    chk("state_ew", cfg_state, 4'd3);
    base = log_n;
    press_next(18'hA5A5);
    press_state(18'h1234);
    chk("ew_still", cfg_state, 4'd3);
    press_next(18'hA5A5);
    sw = 18'h1234;
    cycles(2);
    press(1'b1, 1'b1, 12);
    chk("ew_count", log_n - base, 4);
    chk("ew0", ent(base + 0), {2'b01, 4'd0, 16'hA5A5});
    chk("ew1", ent(base + 1), {2'b01, 4'd1, 16'h1234});
    chk("ew2", ent(base + 2), {2'b10, 4'd0, 16'hA5A5});
    chk("ew3", ent(base + 3), {2'b10, 4'd1, 16'h1234});
    chk("state_sa", cfg_state, 4'd4);
    press_state(18'd4090);
    press_state(18'd16);
    chk("start_addr", mst_start_addr, {12'd16, 12'd4090});
    chk("state_ac", cfg_state, 4'd5);
    press_state(18'd100);
    chk("count_clamp", mst_addr_count[11:0], 12'd6);
    sw = 18'd50;
    cycles(2);
    press(1'b1, 1'b0, 3);
    chk("glitch_state", cfg_state, 4'd5);
    press_state(18'd7);
    chk("count", mst_addr_count, {12'd7, 12'd6});
    chk("ready", {cfg_state, comm_ready}, {4'd6, 1'b1});
    cs0 = cs_cnt;
    press_state(18'd0);
    chk("comm_start_1cyc", cs_cnt - cs0, 1);
    chk("comm", {cfg_state, comm_ready}, {4'd7, 1'b0});
    press_state(18'd0);
    chk("comm_ignore", cfg_state, 4'd7);
    comm_done = 1'b1;
    cycles(2);
    comm_done = 1'b0;
    chk("done", {cfg_state, comm_finished}, {4'd8, 1'b1});
    rd0 = rd_cnt;
    press_state(18'd3);
    chk("rd_addr", rd_addr, 12'd3);
    chk("rd_req_1cyc", rd_cnt - rd0, 1);
    chk("done_stay", cfg_state, 4'd8);
    chk("cs_total", cs_cnt - cs0, 1);

    // Pass 2: only master 1 writes; saturate the write index.
    do_reset();
    chk("rst2_state", cfg_state, 4'd0);
    press_state(18'd0);
    press_state(18'd0);
    press_state(18'h2);
    chk("state_ew2", cfg_state, 4'd3);
    base = log_n;
    for (int i = 0; i < 20; i++) press_next(18'h100 + 18'(i));
    chk("sat_count", log_n - base, 15);
    chk("sat_first", ent(base + 0), {2'b10, 4'd0, 16'h0100});
    chk("sat_last", ent(base + 14), {2'b10, 4'd14, 16'h010E});
    press_state(18'hBEEF);
    chk("sat_final_n", log_n - base, 16);
    chk("sat_final", ent(base + 15), {2'b10, 4'd15, 16'hBEEF});
    chk("state_sa2", cfg_state, 4'd4);
    press_state(18'd4095);
    press_state(18'd0);
    press_state(18'd1);
    press_state(18'd4095);
    chk("count_edge", mst_addr_count, {12'd4095, 12'd1});
    press_state(18'd0);
    chk("comm2", cfg_state, 4'd7);
    cs0 = cs_cnt;
    rd0 = rd_cnt;
    base = log_n;
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    chk("async_state", cfg_state, 4'd0);
    chk("async_cfg", {mst_slave_sel, mst_rw, mst_ext_en, mst_start_addr, mst_addr_count}, '0);
    chk("async_out", {comm_ready, comm_finished, rd_addr, ext_wr_addr, ext_wr_data}, '0);
    cycles(3);
    chk("rst_no_strobe", (log_n - base) + (cs_cnt - cs0) + (rd_cnt - rd0), 0);
    rstN = 1'b1;
    cycles(14);

    // Pass 3: no external writes at all.
    base = log_n;
    press_state(18'd0);
    press_state(18'd0);
    press_state(18'd0);
    chk("skip_ew", cfg_state, 4'd4);
    chk("skip_no_wr", log_n - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
